svc_rv_perf_ctr: RTL and testbench
==================================

// Module: svc_rv_perf_ctr
//
// PURPOSE
// Performance-counter unit for the RV core. Counts cycles, retired instructions
// and stall cycles, and serves them to the core's CSR stage (rdcycle/rdinstret)
// with a one-cycle registered read port. Software uses these reads to compute CPI.
// Counting freezes permanently on halt (ebreak), so a bench can read CPI after
// the program stops.
//
// PARAMETERS
// XLEN   32  CSR data width; counters are 2*XLEN bits, read/written as lo/hi halves
//
// PORTS
// clk           in   1     clock
// rst           in   1     reset (one clock; reset is synchronous and active-high)
// retire        in   1     one instruction retired this cycle
// stall         in   1     pipeline stalled this cycle
// halt          in   1     ebreak retired this cycle; freezes all counters
// csr_rd_en     in   1     CSR read request
// csr_wr_en     in   1     CSR write request
// csr_addr      in   12    CSR address for the read or write
// csr_wr_data   in   XLEN  write data
// csr_rd_valid  out  1     read response valid (1 cycle after csr_rd_en)
// csr_rd_data   out  XLEN  read response data
// csr_rd_err    out  1     read addressed an unmapped CSR (valid with csr_rd_valid)
// halted        out  1     unit is in HALTED state
//
// BEHAVIOUR
// - Reset: cycle/instret/stall counters=0, inhibit=0, state RUN, csr_rd_valid=0,
//   csr_rd_data=0, csr_rd_err=0, halted=0. Reset mid-run clears everything,
//   including HALTED and any in-flight read response.
// - FSM: RUN -> HALTED when halt=1. HALTED is left only by rst. halted = (state==HALTED).
// - Counting (RUN only): cycle +1 every cycle unless inhibit[0]; instret +1 when
//   retire unless inhibit[2]; stall +1 when stall unless inhibit[3].
// - The halt cycle is still counted: cycle and retire/stall in that cycle increment.
//   From the next cycle on, no counter changes except by CSR write.
// - Counters are 2*XLEN bits and wrap from all-ones to 0 with no flag.
// - CSR map (R = read-only, RW = read/write):
//   0xC00/0xC80 cycle lo/hi (R)      0xB00/0xB80 mcycle lo/hi (RW)
//   0xC02/0xC82 instret lo/hi (R)    0xB02/0xB82 minstret lo/hi (RW)
//   0xC03/0xC83 stall lo/hi (R)      0xB03/0xB83 mhpmcounter3 lo/hi (RW)
//   0x320 mcountinhibit (RW; bits 0,2,3 implemented, all other bits read 0)
// - Reads of any other address: csr_rd_err=1, csr_rd_data=0.
// - Writes to read-only or unmapped addresses are ignored silently.
// - Write vs increment in the same cycle: the write wins. The written half takes
//   csr_wr_data, the other half keeps its value, and that counter does not
//   increment that cycle. Writes are honoured in HALTED state as well.
// - Read latency is 1 cycle. csr_rd_data is the value the counter held at the
//   start of the request cycle (pre-increment, pre-write). csr_rd_valid pulses
//   exactly one cycle per request. Back-to-back requests give back-to-back responses.
// - A read and a write to the same address in the same cycle return the old value.
// - The hi half is not latched on a lo read. Software handles lo/hi tearing with
//   the standard hi-lo-hi read sequence.
//
// TESTING
// 1. Reset, then 100 idle cycles; read 0xC00 -> csr_rd_valid 1 cycle later,
//    data=100; 0xC80 -> 0.
// 2. Assert retire on 37 of 50 cycles, stall on 13 -> reads of 0xC02=37,
//    0xC03=13.
// 3. Halt on cycle N with retire=1 -> halted=1 from N+1. instret includes the
//    ebreak. Cycle reads stay constant across 20 more cycles.
// 4. Write 0xB00=0xFFFF_FFFF and 0xB80=0xFFFF_FFFF, then run 2 cycles ->
//    counter wraps; 0xC00=1, 0xC80=0.
// 5. Write 0x320=0x5, then pulse retire for 10 cycles -> cycle and instret
//    frozen, stall still counts. Read 0x320 -> 0x5. Reading 0x321 gives
//    csr_rd_err=1, data=0.
// 6. Write 0xB02 and read 0xC02 in the same cycle -> old value returned; the
//    next read returns the written value, with no increment in the write cycle.
//    Assert rst while halted -> all counters=0 and halted=0.

Source files
------------

// File: rtl/svc_rv_perf_ctr_if.sv
// CSR access port between the core's CSR stage and the performance-counter unit.
// The master issues read/write requests; the slave returns a registered read response.
interface svc_rv_perf_ctr_if #(
   parameter int XLEN = 32
);
   logic            csr_rd_en;
   logic            csr_wr_en;
   logic [11:0]     csr_addr;
   logic [XLEN-1:0] csr_wr_data;
   logic            csr_rd_valid;
   logic [XLEN-1:0] csr_rd_data;
   logic            csr_rd_err;

   modport master (
      output csr_rd_en,
      output csr_wr_en,
      output csr_addr,
      output csr_wr_data,
      input  csr_rd_valid,
      input  csr_rd_data,
      input  csr_rd_err
   );

   modport slave (
      input  csr_rd_en,
      input  csr_wr_en,
      input  csr_addr,
      input  csr_wr_data,
      output csr_rd_valid,
      output csr_rd_data,
      output csr_rd_err
   );
endinterface

// File: rtl/svc_rv_perf_ctr.sv
// Cycle / instret / stall performance counters with a one-cycle registered CSR read
// port. Counting freezes for good on halt; only rst leaves the HALTED state.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_RUN  | counters advance (subject to mcountinhibit)
// ST_HALT | ebreak seen; counters change only through CSR writes
module svc_rv_perf_ctr #(
   parameter int XLEN = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 retire,
   input  logic                 stall,
   input  logic                 halt,
   output logic                 halted,
   svc_rv_perf_ctr_if.slave     csr
);
   localparam int CW = 2 * XLEN;

   localparam logic [11:0] A_CYCLE     = 12'hC00;
   localparam logic [11:0] A_CYCLEH    = 12'hC80;
   localparam logic [11:0] A_INSTRET   = 12'hC02;
   localparam logic [11:0] A_INSTRETH  = 12'hC82;
   localparam logic [11:0] A_STALL     = 12'hC03;
   localparam logic [11:0] A_STALLH    = 12'hC83;
   localparam logic [11:0] A_MCYCLE    = 12'hB00;
   localparam logic [11:0] A_MCYCLEH   = 12'hB80;
   localparam logic [11:0] A_MINSTRET  = 12'hB02;
   localparam logic [11:0] A_MINSTRETH = 12'hB82;
   localparam logic [11:0] A_MHPM3     = 12'hB03;
   localparam logic [11:0] A_MHPM3H    = 12'hB83;
   localparam logic [11:0] A_INHIBIT   = 12'h320;

   typedef enum logic {
      ST_RUN,
      ST_HALT
   } state_t;

   state_t state_q, state_d;
   logic   count_en;

   logic [CW-1:0] cyc_q, ins_q, stl_q;
   logic          inh_cy_q, inh_ir_q, inh_st_q;

   logic [XLEN-1:0] inhibit_rd;
   logic [XLEN-1:0] rd_mux;
   logic            rd_hit;

   logic            rd_valid_q;
   logic [XLEN-1:0] rd_data_q;
   logic            rd_err_q;

   logic wr_cyc_lo, wr_cyc_hi, wr_ins_lo, wr_ins_hi, wr_stl_lo, wr_stl_hi, wr_inh;
   logic inc_cyc, inc_ins, inc_stl;

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk) begin
      if (rst) state_q <= ST_RUN;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d  = state_q;
      count_en = 1'b0;
      halted   = 1'b0;
      case (state_q)
         ST_RUN: begin
            count_en = 1'b1;
            if (halt) state_d = ST_HALT;
         end
         ST_HALT: begin
            halted = 1'b1;
         end
         default: state_d = ST_RUN;
      endcase
   end

   // ---------------------------------------------------------------- write decode
   always_comb begin
      wr_cyc_lo = csr.csr_wr_en && (csr.csr_addr == A_MCYCLE);
      wr_cyc_hi = csr.csr_wr_en && (csr.csr_addr == A_MCYCLEH);
      wr_ins_lo = csr.csr_wr_en && (csr.csr_addr == A_MINSTRET);
      wr_ins_hi = csr.csr_wr_en && (csr.csr_addr == A_MINSTRETH);
      wr_stl_lo = csr.csr_wr_en && (csr.csr_addr == A_MHPM3);
      wr_stl_hi = csr.csr_wr_en && (csr.csr_addr == A_MHPM3H);
      wr_inh    = csr.csr_wr_en && (csr.csr_addr == A_INHIBIT);
   end

   // The halt cycle itself is still in ST_RUN, so it is counted.
   assign inc_cyc = count_en && !inh_cy_q;
   assign inc_ins = count_en && retire && !inh_ir_q;
   assign inc_stl = count_en && stall  && !inh_st_q;

   // A write to either half takes priority over the increment of that counter.
   function automatic logic [CW-1:0] ctr_next(
      input logic [CW-1:0]   cur,
      input logic            wr_lo,
      input logic            wr_hi,
      input logic [XLEN-1:0] wdata,
      input logic            inc
   );
      logic [CW-1:0] nxt;
      nxt = cur;
      if (wr_lo)      nxt = {cur[CW-1:XLEN], wdata};
      else if (wr_hi) nxt = {wdata, cur[XLEN-1:0]};
      else if (inc)   nxt = cur + {{(CW-1){1'b0}}, 1'b1};
      return nxt;
   endfunction

   // ---------------------------------------------------------------- counters
   always_ff @(posedge clk) begin
      if (rst) begin
         cyc_q    <= '0;
         ins_q    <= '0;
         stl_q    <= '0;
         inh_cy_q <= 1'b0;
         inh_ir_q <= 1'b0;
         inh_st_q <= 1'b0;
      end else begin
         cyc_q <= ctr_next(cyc_q, wr_cyc_lo, wr_cyc_hi, csr.csr_wr_data, inc_cyc);
         ins_q <= ctr_next(ins_q, wr_ins_lo, wr_ins_hi, csr.csr_wr_data, inc_ins);
         stl_q <= ctr_next(stl_q, wr_stl_lo, wr_stl_hi, csr.csr_wr_data, inc_stl);
         if (wr_inh) begin
            inh_cy_q <= csr.csr_wr_data[0];
            inh_ir_q <= csr.csr_wr_data[2];
            inh_st_q <= csr.csr_wr_data[3];
         end
      end
   end

   // ---------------------------------------------------------------- read port
   assign inhibit_rd = {{(XLEN-4){1'b0}}, inh_st_q, inh_ir_q, 1'b0, inh_cy_q};

   always_comb begin
      rd_mux = '0;
      rd_hit = 1'b1;
      case (csr.csr_addr)
         A_CYCLE,   A_MCYCLE:    rd_mux = cyc_q[XLEN-1:0];
         A_CYCLEH,  A_MCYCLEH:   rd_mux = cyc_q[CW-1:XLEN];
         A_INSTRET, A_MINSTRET:  rd_mux = ins_q[XLEN-1:0];
         A_INSTRETH, A_MINSTRETH: rd_mux = ins_q[CW-1:XLEN];
         A_STALL,   A_MHPM3:     rd_mux = stl_q[XLEN-1:0];
         A_STALLH,  A_MHPM3H:    rd_mux = stl_q[CW-1:XLEN];
         A_INHIBIT:              rd_mux = inhibit_rd;
         default:                rd_hit = 1'b0;
      endcase
   end

   // Samples pre-update state, so a same-cycle write or increment is not visible.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_valid_q <= 1'b0;
         rd_data_q  <= '0;
         rd_err_q   <= 1'b0;
      end else begin
         rd_valid_q <= csr.csr_rd_en;
         if (csr.csr_rd_en) begin
            rd_data_q <= rd_mux;
            rd_err_q  <= !rd_hit;
         end
      end
   end

   assign csr.csr_rd_valid = rd_valid_q;
   assign csr.csr_rd_data  = rd_data_q;
   assign csr.csr_rd_err   = rd_err_q;

endmodule

// File: tb/tb_svc_rv_perf_ctr.sv
// Directed bench for svc_rv_perf_ctr: reads push hand-computed expectations into a
// queue, and a negedge monitor pops and compares every response it sees.
module tb_svc_rv_perf_ctr;
   logic clk = 1'b0;
   logic rst, retire, stall, halt;
   logic halted;

   svc_rv_perf_ctr_if #(.XLEN(32)) csr ();

   svc_rv_perf_ctr #(.XLEN(32)) dut (
      .clk    (clk),
      .rst    (rst),
      .retire (retire),
      .stall  (stall),
      .halt   (halt),
      .halted (halted),
      .csr    (csr)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] data;
      logic        err;
      int          due;
      logic [11:0] addr;
   } exp_t;

   exp_t exp_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   int   cyc_n   = 0;

   always @(posedge clk) cyc_n <= cyc_n + 1;

   // Response monitor
   always @(negedge clk) begin
      if (csr.csr_rd_valid) begin
         n_tests++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_rsp: got data=%h err=%0b, required no response", csr.csr_rd_data, csr.csr_rd_err);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            if (csr.csr_rd_data !== e.data || csr.csr_rd_err !== e.err || cyc_n != e.due) begin
               n_fail++;
               $display("FAIL rd_%h: got data=%h err=%0b cyc=%0d, required data=%h err=%0b cyc=%0d",
                        e.addr, csr.csr_rd_data, csr.csr_rd_err, cyc_n, e.data, e.err, e.due);
            end
         end
      end
   end

   task automatic drive(input logic r_rst, input logic r_ret, input logic r_stl, input logic r_hlt,
                        input logic r_rd, input logic r_wr, input logic [11:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp_data, input logic exp_err);
      exp_t e;
      rst              = r_rst;
      retire           = r_ret;
      stall            = r_stl;
      halt             = r_hlt;
      csr.csr_rd_en    = r_rd;
      csr.csr_wr_en    = r_wr;
      csr.csr_addr     = addr;
      csr.csr_wr_data  = wdata;
      if (r_rd && !r_rst) begin
         e.data = exp_data;
         e.err  = exp_err;
         e.due  = cyc_n + 1;
         e.addr = addr;
         exp_q.push_back(e);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n, input logic r_ret, input logic r_stl);
      for (int i = 0; i < n; i++) drive(0, r_ret, r_stl, 0, 0, 0, 12'h0, 32'h0, 32'h0, 0);
   endtask

   task automatic do_rst();
      drive(1, 0, 0, 0, 0, 0, 12'h0, 32'h0, 32'h0, 0);
   endtask

   task automatic rd(input logic [11:0] addr, input logic [31:0] exp_data, input logic exp_err);
      drive(0, 0, 0, 0, 1, 0, addr, 32'h0, exp_data, exp_err);
   endtask

   task automatic wr(input logic [11:0] addr, input logic [31:0] wdata);
      drive(0, 0, 0, 0, 0, 1, addr, wdata, 32'h0, 0);
   endtask

   task automatic check_bit(input string name, input logic act, input logic req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0b, required %0b", name, act, req);
      end
   endtask

   initial begin
      // Reset with a simultaneous read: that request must never produce a response.
      drive(1, 0, 0, 0, 1, 0, 12'hC00, 32'h0, 32'h0, 0);
      check_bit("rst_halted", halted, 1'b0);
      check_bit("rst_rd_valid", csr.csr_rd_valid, 1'b0);
      idle(100, 0, 0);
      rd(12'hC00, 32'd100, 0);
      rd(12'hC80, 32'd0, 0);

      // Retire / stall counting
      do_rst();
      for (int i = 0; i < 50; i++) drive(0, i < 37, i >= 37, 0, 0, 0, 12'h0, 32'h0, 32'h0, 0);
      rd(12'hC02, 32'd37, 0);
      rd(12'hC03, 32'd13, 0);

      // Halt with retire: cycle 52 -> 53, instret 37 -> 38, then frozen
      check_bit("pre_halt", halted, 1'b0);
      drive(0, 1, 0, 1, 0, 0, 12'h0, 32'h0, 32'h0, 0);
      check_bit("halted_set", halted, 1'b1);
      idle(20, 1, 1);
      rd(12'hC00, 32'd53, 0);
      rd(12'hC02, 32'd38, 0);
      rd(12'hC03, 32'd13, 0);
      rd(12'hC00, 32'd53, 0);
      wr(12'hB03, 32'h77);
      rd(12'hC03, 32'h77, 0);
      check_bit("still_halted", halted, 1'b1);
      do_rst();
      check_bit("rst_clears_halt", halted, 1'b0);
      rd(12'hC00, 32'd0, 0);
      rd(12'hC02, 32'd0, 0);
      rd(12'hC03, 32'd0, 0);

      // 64-bit wrap
      do_rst();
      wr(12'hB00, 32'hFFFF_FFFF);
      wr(12'hB80, 32'hFFFF_FFFF);
      idle(2, 0, 0);
      rd(12'hC00, 32'd1, 0);
      rd(12'hC80, 32'd0, 0);

      // Inhibit cycle and instret; the write cycle still counts one cycle
      do_rst();
      wr(12'h320, 32'h5);
      idle(10, 1, 1);
      rd(12'hC00, 32'd1, 0);
      rd(12'hC02, 32'd0, 0);
      rd(12'hC03, 32'd10, 0);
      rd(12'h320, 32'h5, 0);
      rd(12'h321, 32'h0, 1);
      wr(12'hC00, 32'h55);
      rd(12'hC00, 32'd1, 0);
      wr(12'h320, 32'hFFFF_FFFF);
      rd(12'h320, 32'hD, 0);

      // Write vs read vs increment in the same cycle
      do_rst();
      idle(5, 1, 0);
      drive(0, 1, 0, 0, 1, 1, 12'hB02, 32'h100, 32'd5, 0);
      rd(12'hC02, 32'h100, 0);
      rd(12'hC82, 32'h0, 0);
      rd(12'hB02, 32'h100, 0);

      idle(3, 0, 0);
      n_tests++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL missing_rsp: got %0d outstanding, required 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
